// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : operand_loader
// Function : Front end for the 4-bit ALU. Synchronises and debounces three
//            push buttons, captures the synchronised switch value into
//            operand A, operand B or the opcode on each debounced press,
//            and flags when all three fields hold valid data.
// Revision : 1.0 - initial release
// ============================================================================
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  input  logic [3:0] no,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [1:0] select,
  output logic [2:0] loaded,
  output logic       valid,
  output logic       start
);

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_READY = 1'b1
  } state_t;

  // Two-stage synchronisers for buttons and switches
  logic [2:0] push_s1_q, push_s1_d, push_s2_q, push_s2_d;
  logic [3:0] no_s1_q, no_s1_d, no_s2_q, no_s2_d;

  // Debounced button levels and their one-cycle-old copy for edge detection
  logic [2:0] db_vec;
  logic [2:0] db_prev_q, db_prev_d;
  logic [2:0] rise;

  // Captured fields and control
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] select_q, select_d;
  logic [2:0] loaded_q, loaded_d;
  logic       load_pulse_q, load_pulse_d;
  logic       start_q, start_d;
  state_t     state_q, state_d;

  // One debouncer per button: flips only after an unbroken run of mismatches
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_debounce
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             db_q, db_d;

      // Next-state for counter and debounced level
      always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (push_s2_q[gi] == db_q) begin
          cnt_d = '0;
        end else if (cnt_q == C_CNT_LAST) begin
          db_d  = push_s2_q[gi];
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Debouncer state registers
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
          db_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          db_q  <= db_d;
        end
      end

      assign db_vec[gi] = db_q;
    end
  endgenerate

  assign rise = db_vec & ~db_prev_q;

  // Next-state for synchronisers, field capture, priority and start pulse
  always_comb begin
    push_s1_d    = {push3, push2, push1};
    push_s2_d    = push_s1_q;
    no_s1_d      = no;
    no_s2_d      = no_s1_q;
    db_prev_d    = db_vec;
    a_d          = a_q;
    b_d          = b_q;
    select_d     = select_q;
    loaded_d     = loaded_q;
    state_d      = state_q;
    load_pulse_d = |rise;
    // push1 wins over push2 wins over push3; losers in the same cycle are dropped
    if (rise[0]) begin
      a_d         = no_s2_q;
      loaded_d[0] = 1'b1;
    end else if (rise[1]) begin
      b_d         = no_s2_q;
      loaded_d[1] = 1'b1;
    end else if (rise[2]) begin
      select_d    = no_s2_q[1:0];
      loaded_d[2] = 1'b1;
    end
    if (loaded_d == 3'b111) begin
      state_d = S_READY;
    end
    // The pulse trails the load by one cycle so the ALU sees settled operands
    start_d = load_pulse_q && (state_q == S_READY);
  end

  // Main state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push_s1_q    <= '0;
      push_s2_q    <= '0;
      no_s1_q      <= '0;
      no_s2_q      <= '0;
      db_prev_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      select_q     <= '0;
      loaded_q     <= '0;
      load_pulse_q <= 1'b0;
      start_q      <= 1'b0;
      state_q      <= S_EMPTY;
    end else begin
      push_s1_q    <= push_s1_d;
      push_s2_q    <= push_s2_d;
      no_s1_q      <= no_s1_d;
      no_s2_q      <= no_s2_d;
      db_prev_q    <= db_prev_d;
      a_q          <= a_d;
      b_q          <= b_d;
      select_q     <= select_d;
      loaded_q     <= loaded_d;
      load_pulse_q <= load_pulse_d;
      start_q      <= start_d;
      state_q      <= state_d;
    end
  end

  assign a      = a_q;
  assign b      = b_q;
  assign select = select_q;
  assign loaded = loaded_q;
  assign valid  = (state_q == S_READY);
  assign start  = start_q;

endmodule
`default_nettype wire
